wb_led_ctrl: RTL and testbench
==============================

WB_LED_CTRL -- requirements
Module: wb_led_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000; Wishbone base address of the register window.
REQ-002 Parameter LED_LSB, default 18; first mprj IO bit driven by LED[0].
REQ-003 Parameter NUM_LEDS, default 8; LED count, fixed at 8.
REQ-004 Ports, in this order:
- wb_clk_i input 1: the single clock.
- wb_rst_i input 1: reset, synchronous and active-high.
- wbs_cyc_i input 1: bus cycle.
- wbs_stb_i input 1: strobe.
- wbs_we_i input 1: write enable.
- wbs_sel_i input 4: byte selects.
- wbs_adr_i input 32: byte address.
- wbs_dat_i input 32: write data.
- wbs_ack_o output 1: acknowledge.
- wbs_dat_o output 32: read data.
- io_out output 38: user IO output values.
- io_oeb output 38: user IO output-enable, active-low.

Function
REQ-005 Request = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]). Offset = wbs_adr_i[7:0].
REQ-006 Ack timing:
- wbs_ack_o pulses high exactly one cycle after a request is sampled with ack low.
- Ack is low in the following cycle even if the strobe is still held.
- Net effect: at most one ack every two cycles.
REQ-007 Writes commit on the ack cycle. Each byte lane is updated only where wbs_sel_i[n]=1, and only the bits that exist in that register.
REQ-008 Register map (all other offsets read 0 and ignore writes):
- 0x00 LED: RW, bits [7:0]; steady LED value.
- 0x04 BLINK_EN: RW, bits [7:0]; per-LED blink enable.
- 0x08 PERIOD: RW, bits [23:0]; half-period of blinking, in clocks.
- 0x0C ID: RO, constant 32'h4C45_4431.
REQ-009 wbs_dat_o presents the addressed register, zero-extended, during the ack cycle, and is 0 otherwise.
REQ-010 Blink timer, when PERIOD != 0:
- counter increments every clock.
- When counter == PERIOD-1: counter wraps to 0 and phase toggles.
REQ-011 When PERIOD == 0, counter and phase are held at 0.
REQ-012 Any write to PERIOD clears counter and phase in the same cycle the write commits.
REQ-013 If a PERIOD write and a wrap happen in the same cycle, the write wins: counter=0, phase=0.
REQ-014 For i in 0..7: io_out[LED_LSB+i] = LED[i] ^ (BLINK_EN[i] & phase). These outputs are registered.
REQ-015 io_oeb[LED_LSB+i] = 0 for all 8 LED bits. All other io_oeb bits = 1 and all other io_out bits = 0.
REQ-016 Accesses with wbs_cyc_i or wbs_stb_i low, or with an address outside the window, produce no ack and no state change.

Reset
REQ-017 While wb_rst_i is high at a clock edge, the following are cleared to 0: LED, BLINK_EN, PERIOD, counter, phase, wbs_ack_o, wbs_dat_o, and the LED io_out bits.
REQ-018 Reset asserted mid-transaction aborts it:
- No ack is issued.
- A pending write does not commit.
- The master must re-issue the request after reset.

Structure
REQ-019 A shared package wb_led_pkg holds:
- register offsets (0x00, 0x04, 0x08, 0x0C);
- the ID constant;
- LED width 8 and PERIOD width 24.
REQ-020 One sub-module, led_blinker, contains the counter and phase logic.
- Inputs: clock, reset, period, period_wr.
- Output: phase.
REQ-021 Top-level RTL contains only the bus decode, the registers and the IO mapping.

Verification
REQ-022 Reset, then read 0x0C -> wbs_dat_o=32'h4C45_4431 with ack exactly one cycle after the strobe. Read 0x00 -> 0.
REQ-023 Write 0x00=8'h80 with sel=4'b0001 -> io_out[25]=1, io_out[24:18]=0, io_oeb[25:18]=0. Then write 0x00=0 -> io_out[25]=0.
REQ-024 Write 0x00=32'h0000_0000 with sel=4'b0000 -> LED is unchanged and ack still pulses once.
REQ-025 Write PERIOD=4 and BLINK_EN=8'h80 with LED=0 -> io_out[25] toggles every 4 clocks. Then write PERIOD=0 -> io_out[25]=0 and stays there.
REQ-026 Hold cyc/stb high for 6 cycles on a read -> ack pattern 0,1,0,1,0,1.
REQ-027 Address error and mid-access reset:
- Address 0x3000_0100 -> no ack.
- Assert reset during a pending write to 0x00 -> LED stays 0.

Source files
------------

// File: rtl/wb_led_pkg.sv
// ---------------------------------------------------------------------------
// wb_led_pkg
// Shared definitions for the Wishbone LED controller:
//   - register offsets inside the 256-byte window
//   - the read-only ID constant
//   - LED and PERIOD register widths
//   - register-select enum, offset decoder and byte-lane merge helper
// ---------------------------------------------------------------------------
package wb_led_pkg;

   localparam int unsigned LED_W    = 8;
   localparam int unsigned PERIOD_W = 24;

   localparam logic [7:0] OFF_LED    = 8'h00;
   localparam logic [7:0] OFF_BLINK  = 8'h04;
   localparam logic [7:0] OFF_PERIOD = 8'h08;
   localparam logic [7:0] OFF_ID     = 8'h0C;

   localparam logic [31:0] ID_VALUE = 32'h4C45_4431;

   typedef enum logic [2:0] {
      REG_LED,
      REG_BLINK,
      REG_PERIOD,
      REG_ID,
      REG_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode_offset(input logic [7:0] off);
      case (off)
         OFF_LED:    return REG_LED;
         OFF_BLINK:  return REG_BLINK;
         OFF_PERIOD: return REG_PERIOD;
         OFF_ID:     return REG_ID;
         default:    return REG_NONE;
      endcase
   endfunction

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/led_blinker.sv
// ---------------------------------------------------------------------------
// led_blinker
// Free-running half-period timer that toggles a blink phase.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   period_i    : half-period in clocks; 0 stops the timer with phase low
//   period_wr_i : pulse when PERIOD is written; restarts the timer
//   phase_o     : current blink phase
// ---------------------------------------------------------------------------
module led_blinker
   import wb_led_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic                period_wr_i,
   output logic                phase_o
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      // A PERIOD write outranks a wrap landing in the same cycle.
      if (period_wr_i || (period_i == '0)) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == period_i - PERIOD_W'(1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase_o = phase_q;

endmodule

// File: rtl/wb_led_ctrl.sv
// ---------------------------------------------------------------------------
// wb_led_ctrl
// Wishbone slave with LED, blink-enable, blink-period and ID registers,
// driving 8 LEDs on the user IO bus.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   wbs_*               : Wishbone slave port (ack one cycle after request)
//   io_out / io_oeb     : user IO values and active-low output enables
// ---------------------------------------------------------------------------
module wb_led_ctrl
   import wb_led_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned LED_LSB   = 18,
   parameter int unsigned NUM_LEDS  = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb
);

   logic                req;
   logic                ack_q, ack_d;
   logic                wr_stb;
   logic                period_wr;
   logic                phase;
   reg_sel_e            reg_sel;
   logic [31:0]         rdata;
   logic [31:0]         dat_q;
   logic [LED_W-1:0]    led_q, led_d;
   logic [LED_W-1:0]    blink_q, blink_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [NUM_LEDS-1:0] led_out_q;

   assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // Ack_q low gates the next request, giving at most one ack per two cycles.
   assign ack_d   = req & ~ack_q;
   // Writes land on the edge that raises ack, so they are visible in the
   // ack cycle; a reset on that edge drops both ack and write.
   assign wr_stb  = ack_d & wbs_we_i;
   assign reg_sel = decode_offset(wbs_adr_i[7:0]);

   always_comb begin
      led_d    = led_q;
      blink_d  = blink_q;
      period_d = period_q;
      rdata    = '0;
      case (reg_sel)
         REG_LED: begin
            rdata = 32'(led_q);
            if (wr_stb) led_d = LED_W'(byte_merge(32'(led_q), wbs_dat_i, wbs_sel_i));
         end
         REG_BLINK: begin
            rdata = 32'(blink_q);
            if (wr_stb) blink_d = LED_W'(byte_merge(32'(blink_q), wbs_dat_i, wbs_sel_i));
         end
         REG_PERIOD: begin
            rdata = 32'(period_q);
            if (wr_stb) period_d = PERIOD_W'(byte_merge(32'(period_q), wbs_dat_i, wbs_sel_i));
         end
         REG_ID:  rdata = ID_VALUE;
         default: rdata = '0;
      endcase
   end

   assign period_wr = wr_stb & (reg_sel == REG_PERIOD);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         led_q     <= '0;
         blink_q   <= '0;
         period_q  <= '0;
         led_out_q <= '0;
      end else begin
         ack_q     <= ack_d;
         dat_q     <= ack_d ? rdata : '0;
         led_q     <= led_d;
         blink_q   <= blink_d;
         period_q  <= period_d;
         led_out_q <= led_q ^ (blink_q & {LED_W{phase}});
      end
   end

   led_blinker u_blinker (
      .clk_i       (wb_clk_i),
      .rst_i       (wb_rst_i),
      .period_i    (period_q),
      .period_wr_i (period_wr),
      .phase_o     (phase)
   );

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

   always_comb begin
      io_out                       = '0;
      io_out[LED_LSB +: NUM_LEDS]  = led_out_q;
      io_oeb                       = '1;
      io_oeb[LED_LSB +: NUM_LEDS]  = '0;
   end

endmodule

// File: tb/tb_wb_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_led_ctrl
// Directed self-checking bench for wb_led_ctrl. Inputs change and outputs
// are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_wb_led_ctrl;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_we_i  = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_adr_i = 32'h0;
   logic [31:0] wbs_dat_i = 32'h0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [37:0] io_out;
   logic [37:0] io_oeb;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [37:0] OEB_EXP  = 38'h3F_FC03_FFFF;
   localparam logic [37:0] LED7_EXP = 38'h00_0200_0000;
   localparam logic [31:0] BASE     = 32'h3000_0000;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_led_ctrl dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .io_out    (io_out),
      .io_oeb    (io_oeb)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One bus transfer; lat is the number of cycles until ack, -1 on timeout.
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdata, output int lat);
      lat   = -1;
      rdata = '0;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      for (int i = 1; i <= 6; i++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            lat   = i;
            rdata = wbs_dat_o;
            break;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_dat_i = 32'h0;
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      logic [15:0] blink_seq;
      logic [5:0]  ack_seq;
      logic [37:0] io_acc;

      // Reset state
      repeat (3) @(negedge wb_clk_i);
      check("rst_ack", 64'(wbs_ack_o), 64'h0);
      check("rst_dat", 64'(wbs_dat_o), 64'h0);
      check("rst_io_out", 64'(io_out), 64'h0);
      check("rst_io_oeb", 64'(io_oeb), 64'(OEB_EXP));
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);

      // ID and LED reads
      wb_xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF, rd, lat);
      check("id_data", 64'(rd), 64'h4C45_4431);
      check("id_lat", 64'(lat), 64'd1);
      @(negedge wb_clk_i);
      check("ack_drops", 64'(wbs_ack_o), 64'h0);
      wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat);
      check("led_rst_val", 64'(rd), 64'h0);

      // LED[7] on
      wb_xfer(1'b1, BASE + 32'h00, 32'h80, 4'b0001, rd, lat);
      repeat (2) @(negedge wb_clk_i);
      check("led7_io_out", 64'(io_out), 64'(LED7_EXP));
      check("led7_io_oeb", 64'(io_oeb), 64'(OEB_EXP));

      // Write with no byte lanes: ack but no change
      wb_xfer(1'b1, BASE + 32'h00, 32'h0, 4'b0000, rd, lat);
      check("sel0_lat", 64'(lat), 64'd1);
      wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat);
      check("sel0_led", 64'(rd), 64'h80);

      // LED off
      wb_xfer(1'b1, BASE + 32'h00, 32'h0, 4'b0001, rd, lat);
      repeat (2) @(negedge wb_clk_i);
      check("led_off_io", 64'(io_out), 64'h0);

      // PERIOD byte lanes and width
      wb_xfer(1'b1, BASE + 32'h08, 32'hAB12_3456, 4'hF, rd, lat);
      wb_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, lat);
      check("period_full", 64'(rd), 64'h0012_3456);
      wb_xfer(1'b1, BASE + 32'h08, 32'h0000_7700, 4'b0010, rd, lat);
      wb_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, lat);
      check("period_lane1", 64'(rd), 64'h0012_7756);

      // Blink LED[7] with half-period 4
      wb_xfer(1'b1, BASE + 32'h04, 32'h80, 4'hF, rd, lat);
      wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, rd, lat);
      check("blink_en_rd", 64'(rd), 64'h80);
      wb_xfer(1'b1, BASE + 32'h08, 32'h4, 4'hF, rd, lat);
      blink_seq = '0;
      for (int k = 0; k < 16; k++) begin
         @(negedge wb_clk_i);
         blink_seq[k] = io_out[25];
      end
      check("blink_seq", 64'(blink_seq), 64'hF0F0);

      // PERIOD=0 stops blinking with the LED low
      wb_xfer(1'b1, BASE + 32'h08, 32'h0, 4'hF, rd, lat);
      repeat (2) @(negedge wb_clk_i);
      io_acc = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge wb_clk_i);
         io_acc = io_acc | io_out;
      end
      check("period0_io", 64'(io_acc), 64'h0);

      // Held strobe: ack every other cycle
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = BASE + 32'h0C;
      wbs_sel_i = 4'hF;
      ack_seq[0] = wbs_ack_o;
      for (int k = 1; k < 6; k++) begin
         @(negedge wb_clk_i);
         ack_seq[k] = wbs_ack_o;
         if (k == 5) check("burst_dat", 64'(wbs_dat_o), 64'h4C45_4431);
      end
      check("burst_ack", 64'(ack_seq), 64'h2A);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge wb_clk_i);
      @(negedge wb_clk_i);

      // Unmapped offset inside the window
      wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat);
      check("unmapped_lat", 64'(lat), 64'd1);
      check("unmapped_dat", 64'(rd), 64'h0);

      // Outside the window: no ack, no write
      wb_xfer(1'b1, 32'h3000_0100, 32'hFF, 4'hF, rd, lat);
      check("oow_no_ack", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat);
      check("oow_led", 64'(rd), 64'h0);

      // Set some state, then reset in the middle of a write
      wb_xfer(1'b1, BASE + 32'h00, 32'h3C, 4'hF, rd, lat);
      wb_xfer(1'b1, BASE + 32'h04, 32'h0F, 4'hF, rd, lat);
      wb_xfer(1'b1, BASE + 32'h08, 32'h9, 4'hF, rd, lat);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b1;
      wbs_adr_i = BASE + 32'h00;
      wbs_dat_i = 32'hFF;
      wbs_sel_i = 4'hF;
      wb_rst_i  = 1'b1;
      io_acc = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge wb_clk_i);
         io_acc[0] = io_acc[0] | wbs_ack_o;
      end
      wb_rst_i  = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      @(negedge wb_clk_i);
      io_acc[0] = io_acc[0] | wbs_ack_o;
      check("mid_rst_ack", 64'(io_acc[0]), 64'h0);
      check("mid_rst_io", 64'(io_out), 64'h0);
      wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, lat);
      check("mid_rst_led", 64'(rd), 64'h0);
      wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, rd, lat);
      check("mid_rst_blink", 64'(rd), 64'h0);
      wb_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, lat);
      check("mid_rst_period", 64'(rd), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
